// File: rtl/bil_win_ctrl.sv
// Sequencer for one 11x11 bilateral-filter window: column fill,
// LUT, multiply, row accumulate, normalise divide, pixel handoff.
module bil_win_ctrl #(
  parameter int WIN     = 11,
  parameter int DIV_TMO = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       line_start,
  output logic       col_shift,
  output logic       lut_en,
  output logic       mul_en,
  output logic       mul_cap,
  output logic       acc_clr,
  output logic       acc_en,
  output logic [3:0] acc_row,
  output logic       div_start,
  input  logic       div_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam int FW = $clog2(WIN + 1);
  localparam int TW = $clog2(DIV_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LUT,
    S_MUL,
    S_ACC,
    S_DIV,
    S_OUT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [FW-1:0]   r_fill;
  logic [FW-1:0]   w_fill_nxt;
  logic [3:0]      r_row;
  logic [TW-1:0]   r_tmo;
  logic            r_err;
  logic            w_accept;
  logic            w_div_ok;
  logic            w_tmo_hit;

  assign w_accept  = (r_state == S_IDLE) & pix_valid;
  // tmo==0 marks the div_start cycle, where div_done is not trusted
  assign w_div_ok  = (r_tmo != '0) & div_done;
  assign w_tmo_hit = (r_tmo == TW'(DIV_TMO));

  always_comb begin
    w_fill_nxt = r_fill;
    if (line_start)
      w_fill_nxt = FW'(1);
    else if (r_fill != FW'(WIN))
      w_fill_nxt = r_fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
      r_row  <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) r_fill <= w_fill_nxt;
      if (r_state == S_MUL) r_row <= '0;
      if (r_state == S_ACC) r_row <= r_row + 1'b1;
      if (r_state == S_DIV) r_tmo <= r_tmo + 1'b1;
      else                  r_tmo <= '0;
      if (r_state == S_DIV && !w_div_ok && w_tmo_hit)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept && w_fill_nxt == FW'(WIN))
          w_next = S_LUT;
      S_LUT: w_next = S_MUL;
      S_MUL: w_next = S_ACC;
      S_ACC:
        if (r_row == 4'(WIN - 1))
          w_next = S_DIV;
      S_DIV:
        if (w_div_ok || w_tmo_hit)
          w_next = S_OUT;
      S_OUT:
        if (out_ready)
          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    col_shift = 1'b0;
    lut_en    = 1'b0;
    mul_en    = 1'b0;
    mul_cap   = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_row   = '0;
    div_start = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    err       = r_err;
    unique case (r_state)
      S_IDLE: begin
        pix_ready = 1'b1;
        col_shift = pix_valid;
      end
      S_LUT: lut_en = 1'b1;
      S_MUL: begin
        mul_en  = 1'b1;
        mul_cap = 1'b1;
        acc_clr = 1'b1;
      end
      S_ACC: begin
        acc_en  = 1'b1;
        acc_row = r_row;
      end
      S_DIV: div_start = (r_tmo == '0);
      S_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bil_win_ctrl.sv
// Directed per-cycle vector bench for bil_win_ctrl.
// Table rows carry inputs and hand-derived expected outputs.
module tb_bil_win_ctrl;

  localparam int WIN     = 11;
  localparam int DIV_TMO = 32;

  localparam int K_IDLE = 0;
  localparam int K_LUT  = 1;
  localparam int K_MUL  = 2;
  localparam int K_ACC  = 3;
  localparam int K_DS   = 4;
  localparam int K_DIV  = 5;
  localparam int K_OUT  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       line_start = 1'b0;
  logic       div_done = 1'b0;
  logic       out_ready = 1'b0;
  logic       pix_ready;
  logic       col_shift;
  logic       lut_en;
  logic       mul_en;
  logic       mul_cap;
  logic       acc_clr;
  logic       acc_en;
  logic [3:0] acc_row;
  logic       div_start;
  logic       out_valid;
  logic       busy;
  logic       err;
  logic [14:0] w_act;

  always #5 clk = ~clk;

  bil_win_ctrl #(.WIN(WIN), .DIV_TMO(DIV_TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .line_start(line_start),
    .col_shift (col_shift),
    .lut_en    (lut_en),
    .mul_en    (mul_en),
    .mul_cap   (mul_cap),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_row   (acc_row),
    .div_start (div_start),
    .div_done  (div_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  assign w_act = {pix_ready, col_shift, lut_en, mul_en, mul_cap,
                  acc_clr, acc_en, acc_row, div_start, out_valid,
                  busy, err};

  typedef struct {
    logic        rst;
    logic        pv;
    logic        ls;
    logic        dd;
    logic        ordy;
    logic [14:0] exp;
    string       tag;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [14:0] mk(input int k, input int r,
                                     input bit cs, input bit e);
    logic pr, c, l, m, ac, ae, ds, ov, b;
    logic [3:0] ar;
    {pr, c, l, m, ac, ae, ds, ov, b} = '0;
    ar = '0;
    if (k == K_IDLE) begin pr = 1'b1; c = cs; end
    else if (k == K_LUT) begin l = 1'b1; b = 1'b1; end
    else if (k == K_MUL) begin m = 1'b1; ac = 1'b1; b = 1'b1; end
    else if (k == K_ACC) begin ae = 1'b1; ar = 4'(r); b = 1'b1; end
    else if (k == K_DS) begin ds = 1'b1; b = 1'b1; end
    else if (k == K_DIV) b = 1'b1;
    else begin ov = 1'b1; b = 1'b1; end
    return {pr, c, l, m, m, ac, ae, ar, ds, ov, b, e};
  endfunction

  task automatic add(input logic r, input logic pv, input logic ls,
                     input logic dd, input logic ordy,
                     input logic [14:0] exp, input string tag);
    vec_t v;
    v.rst = r; v.pv = pv; v.ls = ls; v.dd = dd; v.ordy = ordy;
    v.exp = exp; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic check(input string tag, input logic [14:0] act,
                       input logic [14:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", tag, act, exp);
  endtask

  // LUT..OUT; dly<0 means div_done never comes (timeout path)
  task automatic compute(input bit e, input bit ds_dd,
                         input int dly, input int ow);
    bit eo;
    eo = e;
    add(0, 1, 1, 0, 1, mk(K_LUT, 0, 0, e), "lut");
    add(0, 1, 0, 0, 1, mk(K_MUL, 0, 0, e), "mul");
    for (int r = 0; r < WIN; r++)
      add(0, 1, 0, (r == 2), 1, mk(K_ACC, r, 0, e), "acc");
    add(0, 1, 0, ds_dd, 1, mk(K_DS, 0, 0, e), "div_start");
    if (dly < 0) begin
      for (int k = 1; k <= DIV_TMO; k++)
        add(0, 0, 0, 0, 1, mk(K_DIV, 0, 0, e), "div_wait");
      eo = 1'b1;
    end else begin
      for (int k = 1; k <= dly; k++)
        add(0, 0, 0, (k == dly), 1, mk(K_DIV, 0, 0, e), "div");
    end
    for (int k = 0; k < ow; k++)
      add(0, 1, 0, 1, 0, mk(K_OUT, 0, 0, eo), "out_hold");
    add(0, 0, 0, 0, 1, mk(K_OUT, 0, 0, eo), "out");
  endtask

  initial begin
    int cnt;
    bit seen_ov;

    // first pixel: line_start column + 10 more
    for (int i = 0; i < WIN; i++)
      add(0, 1, (i == 0), 0, 0, mk(K_IDLE, 0, 1, 0), "fill");
    compute(0, 0, 3, 0);
    // steady state: one plain column fires a new pixel
    add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 0), "steady_col");
    compute(0, 1, 2, 5);
    // line_start restarts the fill; timeout on this pixel
    add(0, 1, 1, 0, 0, mk(K_IDLE, 0, 1, 0), "ls_col");
    for (int i = 0; i < 9; i++)
      add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 0), "ls_fill");
    add(0, 0, 0, 0, 0, mk(K_IDLE, 0, 0, 0), "ls_gap");
    add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 0), "ls_last");
    compute(0, 0, -1, 0);
    // err stays set on the next pixel
    add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 1), "err_col");
    compute(1, 0, 1, 0);
    // reset in the middle of ACC
    add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 1), "rst_col");
    add(0, 0, 0, 0, 0, mk(K_LUT, 0, 0, 1), "rst_lut");
    add(0, 0, 0, 0, 0, mk(K_MUL, 0, 0, 1), "rst_mul");
    for (int r = 0; r <= 5; r++)
      add((r == 5), 0, 0, 0, 0, mk(K_ACC, r, 0, 1), "rst_acc");
    for (int i = 0; i < WIN; i++)
      add(0, 1, 0, 0, 0, mk(K_IDLE, 0, 1, 0), "refill");
    compute(0, 0, 4, 1);
    add(0, 0, 0, 0, 0, mk(K_IDLE, 0, 0, 0), "idle_end");

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", w_act, mk(K_IDLE, 0, 0, 0));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst        = tbl[i].rst;
      pix_valid  = tbl[i].pv;
      line_start = tbl[i].ls;
      div_done   = tbl[i].dd;
      out_ready  = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tbl[i].tag, i), w_act, tbl[i].exp);
    end

    // minimum pixel period with div_done/out_ready held high
    @(posedge clk);
    #1;
    rst = 0; pix_valid = 1; line_start = 0;
    div_done = 1; out_ready = 1;
    @(negedge clk);
    check("period_accept", {15'(col_shift)}, 15'd1);
    @(posedge clk);
    #1;
    pix_valid = 0;
    cnt = 1;
    seen_ov = 0;
    while (!pix_ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (out_valid) seen_ov = 1;
    end
    check("period_cycles", 15'(cnt), 15'(WIN + 6));
    check("period_out_seen", {15'(seen_ov)}, 15'd1);
    check("period_err", {15'(err)}, 15'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
